// File: rtl/alu_pipe.sv
// Pipelined integer ALU with an in-order result FIFO and credit-based issue backpressure.
// Optional multiply opcodes are built only when ALU_MUL_EN is defined.
module alu_pipe #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ROB_W       = 4,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned RES_DEPTH   = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         clear,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [4:0]                   op,
    input  logic [XLEN-1:0]              lhs,
    input  logic [XLEN-1:0]              rhs,
    input  logic [ROB_W-1:0]             rob_dep,
    input  logic [XLEN-1:0]              true_jaddr,
    input  logic [XLEN-1:0]              false_jaddr,
    output logic                         out_valid,
    output logic [ROB_W-1:0]             out_rob_id,
    output logic [XLEN-1:0]              out_value,
    input  logic                         out_ack,
    output logic [$clog2(RES_DEPTH):0]   occupancy
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned AW  = $clog2(RES_DEPTH);
    localparam int unsigned CW  = AW + 1;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SLL    = 5'b00001;
    localparam logic [4:0] OP_SLT    = 5'b00010;
    localparam logic [4:0] OP_SLTU   = 5'b00011;
    localparam logic [4:0] OP_XOR    = 5'b00100;
    localparam logic [4:0] OP_SR     = 5'b00101;
    localparam logic [4:0] OP_OR     = 5'b00110;
    localparam logic [4:0] OP_AND    = 5'b00111;
    localparam logic [4:0] OP_SUB    = 5'b01000;
    localparam logic [4:0] OP_BEQ    = 5'b10000;
    localparam logic [4:0] OP_BNE    = 5'b10001;
    localparam logic [4:0] OP_BLT    = 5'b10100;
    localparam logic [4:0] OP_BGE    = 5'b10101;
    localparam logic [4:0] OP_BLTU   = 5'b10110;
    localparam logic [4:0] OP_BGEU   = 5'b10111;
`ifdef ALU_MUL_EN
    localparam logic [4:0] OP_MUL    = 5'b11000;
    localparam logic [4:0] OP_MULH   = 5'b11001;
    localparam logic [4:0] OP_MULHSU = 5'b11010;
    localparam logic [4:0] OP_MULHU  = 5'b11011;
`endif

    logic             accept;
    logic             push;
    logic             pop;
    logic [SHW-1:0]   shamt;
    logic             eq;
    logic             lt_s;
    logic             lt_u;
    logic [XLEN-1:0]  sra_res;
    logic [XLEN-1:0]  alu_res;

    logic             wr_valid;
    logic [ROB_W-1:0] wr_rob;
    logic [XLEN-1:0]  wr_value;

    logic [ROB_W-1:0] fifo_rob [RES_DEPTH];
    logic [XLEN-1:0]  fifo_val [RES_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Credit check uses only registered occupancy, so out_ack never reaches issue_ready.
    assign issue_ready = rdy_in & ~clear & (occupancy < CW'(RES_DEPTH));
    assign accept      = issue_valid & issue_ready;

    assign shamt   = rhs[SHW-1:0];
    assign eq      = (lhs == rhs);
    assign lt_s    = ($signed(lhs) < $signed(rhs));
    assign lt_u    = (lhs < rhs);
    assign sra_res = $signed(lhs) >>> shamt;

`ifdef ALU_MUL_EN
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] prod;

    // One 2*XLEN multiplier; operand extension selects the signedness variant.
    always_comb begin
        mul_a = {{XLEN{1'b0}}, lhs};
        mul_b = {{XLEN{1'b0}}, rhs};
        if (op == OP_MULH || op == OP_MULHSU) begin
            mul_a = {{XLEN{lhs[XLEN-1]}}, lhs};
        end
        if (op == OP_MULH) begin
            mul_b = {{XLEN{rhs[XLEN-1]}}, rhs};
        end
    end

    assign prod = mul_a * mul_b;
`endif

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = lhs + rhs;
            OP_SUB:  alu_res = lhs - rhs;
            OP_SLL:  alu_res = lhs << shamt;
            OP_SLT:  alu_res = XLEN'(lt_s);
            OP_SLTU: alu_res = XLEN'(lt_u);
            OP_XOR:  alu_res = lhs ^ rhs;
            OP_OR:   alu_res = lhs | rhs;
            OP_AND:  alu_res = lhs & rhs;
            OP_SR:   alu_res = rhs[10] ? sra_res : (lhs >> shamt);
            OP_BEQ:  alu_res = eq    ? true_jaddr : false_jaddr;
            OP_BNE:  alu_res = !eq   ? true_jaddr : false_jaddr;
            OP_BLT:  alu_res = lt_s  ? true_jaddr : false_jaddr;
            OP_BGE:  alu_res = !lt_s ? true_jaddr : false_jaddr;
            OP_BLTU: alu_res = lt_u  ? true_jaddr : false_jaddr;
            OP_BGEU: alu_res = !lt_u ? true_jaddr : false_jaddr;
`ifdef ALU_MUL_EN
            OP_MUL:                        alu_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  alu_res = prod[2*XLEN-1:XLEN];
`endif
            default: alu_res = '0;
        endcase
    end

    // The FIFO write is the last of the PIPE_STAGES registers; earlier ones delay the result.
    if (PIPE_STAGES == 1) begin : g_direct
        assign wr_valid = accept;
        assign wr_rob   = rob_dep;
        assign wr_value = alu_res;
    end else begin : g_pipe
        localparam int unsigned NREG = PIPE_STAGES - 1;

        logic [NREG-1:0]  pv;
        logic [ROB_W-1:0] prob [NREG];
        logic [XLEN-1:0]  pval [NREG];

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                pv <= '0;
                for (int i = 0; i < int'(NREG); i++) begin
                    prob[i] <= '0;
                    pval[i] <= '0;
                end
            end else if (rdy_in) begin
                if (clear) begin
                    pv <= '0;
                end else begin
                    pv[0]   <= accept;
                    prob[0] <= rob_dep;
                    pval[0] <= alu_res;
                    for (int i = 1; i < int'(NREG); i++) begin
                        pv[i]   <= pv[i-1];
                        prob[i] <= prob[i-1];
                        pval[i] <= pval[i-1];
                    end
                end
            end
        end

        assign wr_valid = pv[NREG-1];
        assign wr_rob   = prob[NREG-1];
        assign wr_value = pval[NREG-1];
    end

    assign push = wr_valid & rdy_in & ~clear;
    assign pop  = out_valid & out_ack & rdy_in & ~clear;

    // Result FIFO; pointers wrap naturally since RES_DEPTH is a power of two.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(RES_DEPTH); i++) begin
                fifo_rob[i] <= '0;
                fifo_val[i] <= '0;
            end
        end else if (rdy_in) begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    fifo_rob[wr_ptr] <= wr_rob;
                    fifo_val[wr_ptr] <= wr_value;
                    wr_ptr           <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Credits: counts every accepted op until its result is popped.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            occupancy <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                occupancy <= '0;
            end else begin
                occupancy <= occupancy + CW'(accept) - CW'(pop);
            end
        end
    end

    assign out_valid  = (count != '0);
    assign out_rob_id = out_valid ? fifo_rob[rd_ptr] : '0;
    assign out_value  = out_valid ? fifo_val[rd_ptr] : '0;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: instance a (1 stage) and instance b (3 stages) share operand
// inputs; each has its own valid/ack, expected-result queue and pop monitor.
module tb_alu_pipe;

    typedef struct packed {
        logic [3:0]  rob;
        logic [31:0] val;
    } exp_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] e;
    } vec_t;

`ifdef ALU_MUL_EN
    localparam logic [31:0] E_MULHU = 32'hFFFF_FFFE;
    localparam logic [31:0] E_MUL   = 32'h0000_0001;
`else
    localparam logic [31:0] E_MULHU = 32'h0;
    localparam logic [31:0] E_MUL   = 32'h0;
`endif

    localparam int NV = 24;
    vec_t vt [NV] = '{
        '{5'b10100, 32'hFFFF_FFFF, 32'h1,        32'h100},        // BLT  -1 < 1
        '{5'b10110, 32'hFFFF_FFFF, 32'h1,        32'h200},        // BLTU
        '{5'b00101, 32'h8000_0000, 32'h404,      32'hF800_0000},  // SRA 4
        '{5'b00101, 32'h8000_0000, 32'h004,      32'h0800_0000},  // SRL 4
        '{5'b00101, 32'h8000_0000, 32'h024,      32'h0800_0000},  // shamt uses low 5 bits only
        '{5'b01000, 32'h5,         32'h7,        32'hFFFF_FFFE},  // SUB wraps
        '{5'b00000, 32'hFFFF_FFFF, 32'h2,        32'h1},          // ADD wraps
        '{5'b00001, 32'h1,         32'h1F,       32'h8000_0000},  // SLL 31
        '{5'b00010, 32'hFFFF_FFFF, 32'h1,        32'h1},          // SLT
        '{5'b00011, 32'hFFFF_FFFF, 32'h1,        32'h0},          // SLTU
        '{5'b00100, 32'hF0F0,      32'hFF00,     32'h0FF0},       // XOR
        '{5'b00110, 32'hF0F0,      32'hFF00,     32'hFFF0},       // OR
        '{5'b00111, 32'hF0F0,      32'hFF00,     32'hF000},       // AND
        '{5'b10000, 32'h3,         32'h3,        32'h100},        // BEQ taken
        '{5'b10001, 32'h3,         32'h3,        32'h200},        // BNE not taken
        '{5'b10101, 32'hFFFF_FFFF, 32'h1,        32'h200},        // BGE -1 >= 1 false
        '{5'b10111, 32'hFFFF_FFFF, 32'h1,        32'h100},        // BGEU
        '{5'b10101, 32'h7,         32'h7,        32'h100},        // BGE equal
        '{5'b01111, 32'h1234,      32'h5678,     32'h0},          // unlisted
        '{5'b11111, 32'h1234,      32'h5678,     32'h0},          // unlisted
        '{5'b11001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0},         // MULH
        '{5'b11011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, E_MULHU},       // MULHU
        '{5'b11000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, E_MUL},         // MUL
        '{5'b11010, 32'h0,         32'hFFFF_FFFF, 32'h0}          // MULHSU of zero
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic [4:0]  op = '0;
    logic [31:0] lhs = '0;
    logic [31:0] rhs = '0;
    logic [3:0]  rob_dep = '0;
    logic [31:0] tj = 32'h100;
    logic [31:0] fj = 32'h200;
    logic [31:0] exp_val = '0;

    logic        iv_a = 1'b0, ack_a = 1'b0, ir_a, ov_a;
    logic        iv_b = 1'b0, ack_b = 1'b0, ir_b, ov_b;
    logic [3:0]  rid_a, rid_b;
    logic [31:0] val_a, val_b;
    logic [2:0]  occ_a, occ_b;

    exp_t qa [$];
    exp_t qb [$];
    int   total = 0;
    int   bad   = 0;

    alu_pipe #(.XLEN(32), .ROB_W(4), .PIPE_STAGES(1), .RES_DEPTH(4)) dut_a (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clear),
        .issue_valid(iv_a), .issue_ready(ir_a), .op(op), .lhs(lhs), .rhs(rhs),
        .rob_dep(rob_dep), .true_jaddr(tj), .false_jaddr(fj),
        .out_valid(ov_a), .out_rob_id(rid_a), .out_value(val_a), .out_ack(ack_a),
        .occupancy(occ_a)
    );

    alu_pipe #(.XLEN(32), .ROB_W(4), .PIPE_STAGES(3), .RES_DEPTH(4)) dut_b (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clear),
        .issue_valid(iv_b), .issue_ready(ir_b), .op(op), .lhs(lhs), .rhs(rhs),
        .rob_dep(rob_dep), .true_jaddr(tj), .false_jaddr(fj),
        .out_valid(ov_b), .out_rob_id(rid_b), .out_value(val_b), .out_ack(ack_b),
        .occupancy(occ_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Inputs only change at posedge+1, so the negedge view predicts the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
        end else if (rdy && clear) begin
            qa.delete();
            qb.delete();
        end else begin
            if (iv_a && ir_a) qa.push_back('{rob: rob_dep, val: exp_val});
            if (iv_b && ir_b) qb.push_back('{rob: rob_dep, val: exp_val});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rdy && !clear && ov_a && ack_a) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected: got rob %0h val %0h want nothing", rid_a, val_a);
            end else begin
                e = qa.pop_front();
                chk("a_rob", 64'(rid_a), 64'(e.rob));
                chk("a_val", 64'(val_a), 64'(e.val));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rdy && !clear && ov_b && ack_b) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected: got rob %0h val %0h want nothing", rid_b, val_b);
            end else begin
                e = qb.pop_front();
                chk("b_rob", 64'(rid_b), 64'(e.rob));
                chk("b_val", 64'(val_b), 64'(e.val));
            end
        end
    end

    task automatic issue(input int s, input logic [4:0] o, input logic [31:0] l, input logic [31:0] r,
                         input logic [3:0] rb, input logic [31:0] e);
        bit ok = 1'b0;
        op = o; lhs = l; rhs = r; rob_dep = rb; exp_val = e;
        if (s == 0) iv_a = 1'b1; else iv_b = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if ((s == 0) ? ir_a : ir_b) ok = 1'b1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL issue_timeout: got ready=0 for 20 cycles want ready=1");
        end
        @(posedge clk); #1;
        iv_a = 1'b0; iv_b = 1'b0;
    endtask

    task automatic drain(input int s);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (s == 0) done = (qa.size() == 0) && !ov_a;
            else        done = (qb.size() == 0) && !ov_b;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL drain_timeout: got results pending want drained (inst %0d)", s);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ov_a", 64'(ov_a), 64'd0);
        chk("rst_occ_a", 64'(occ_a), 64'd0);
        chk("rst_rid_a", 64'(rid_a), 64'd0);
        chk("rst_val_a", 64'(val_a), 64'd0);
        chk("rst_ready_a", 64'(ir_a), 64'd1);
        chk("rst_ov_b", 64'(ov_b), 64'd0);
        chk("rst_occ_b", 64'(occ_b), 64'd0);
        @(posedge clk); #1;

        // Single ADD, one-stage latency, then pop.
        issue(0, 5'b00000, 32'd5, 32'd7, 4'd3, 32'd12);
        @(negedge clk);
        chk("add_ov", 64'(ov_a), 64'd1);
        chk("add_rid", 64'(rid_a), 64'd3);
        chk("add_val", 64'(val_a), 64'd12);
        chk("add_occ", 64'(occ_a), 64'd1);
        @(posedge clk); #1 ack_a = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pop_ov", 64'(ov_a), 64'd0);
        chk("pop_occ", 64'(occ_a), 64'd0);
        @(posedge clk); #1;

        // Back-to-back stream with out_ack held: accept+pop keeps occupancy at 1.
        for (int i = 0; i < NV; i++) issue(0, vt[i].op, vt[i].l, vt[i].r, 4'(i), vt[i].e);
        @(negedge clk);
        chk("stream_occ", 64'(occ_a), 64'd1);
        drain(0);

        // Backpressure: four stored results block issue until one is acked.
        ack_a = 1'b0;
        for (int i = 1; i <= 4; i++) issue(0, 5'b00000, 32'(i), 32'd100, 4'(i), 32'(i + 100));
        @(negedge clk);
        chk("bp_occ_full", 64'(occ_a), 64'd4);
        chk("bp_ready_low", 64'(ir_a), 64'd0);
        @(posedge clk); #1;
        fork
            issue(0, 5'b00000, 32'd5, 32'd100, 4'd5, 32'd105);
            begin
                @(negedge clk);
                chk("bp_still_blocked", 64'(ir_a), 64'd0);
                @(posedge clk); #1 ack_a = 1'b1;
                @(posedge clk); #1 ack_a = 1'b0;
            end
        join
        @(negedge clk);
        chk("bp_refill_occ", 64'(occ_a), 64'd4);
        chk("bp_head_rid", 64'(rid_a), 64'd2);
        @(posedge clk); #1 ack_a = 1'b1;
        issue(0, 5'b00000, 32'd6, 32'd100, 4'd6, 32'd106);
        drain(0);
        ack_a = 1'b0;

        // Three-stage latency.
        issue(1, 5'b00000, 32'd1, 32'd1, 4'd5, 32'd2);
        @(negedge clk); chk("lat3_e0", 64'(ov_b), 64'd0);
        @(negedge clk); chk("lat3_e1", 64'(ov_b), 64'd0);
        @(negedge clk); chk("lat3_e2", 64'(ov_b), 64'd1);
        chk("lat3_occ", 64'(occ_b), 64'd1);
        @(posedge clk); #1 ack_b = 1'b1;
        drain(1);
        ack_b = 1'b0;

        // Flush with one stored and two in flight; the op offered during clear is dropped.
        for (int i = 1; i <= 3; i++) issue(1, 5'b00100, 32'(i), 32'hFF, 4'(i), 32'(i) ^ 32'hFF);
        clear = 1'b1; iv_b = 1'b1; op = 5'b00000; lhs = 32'd9; rhs = 32'd9; rob_dep = 4'd9; exp_val = 32'd18;
        @(negedge clk);
        chk("clr_ready_low", 64'(ir_b), 64'd0);
        chk("clr_pre_occ", 64'(occ_b), 64'd3);
        chk("clr_pre_ov", 64'(ov_b), 64'd1);
        @(posedge clk); #1 clear = 1'b0; iv_b = 1'b0;
        @(negedge clk);
        chk("clr_ov", 64'(ov_b), 64'd0);
        chk("clr_occ", 64'(occ_b), 64'd0);
        @(posedge clk); #1 ack_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("clr_stays_empty", 64'(ov_b), 64'd0);
        end
        @(posedge clk); #1 ack_b = 1'b0;

        // Pause: rdy low freezes head, occupancy and pipeline even with out_ack high.
        for (int i = 4; i <= 6; i++) issue(1, 5'b00000, 32'(i), 32'd1000, 4'(i), 32'(i + 1000));
        rdy = 1'b0; ack_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("pause_occ", 64'(occ_b), 64'd3);
            chk("pause_ov", 64'(ov_b), 64'd1);
            chk("pause_rid", 64'(rid_b), 64'd4);
            chk("pause_val", 64'(val_b), 64'd1004);
            chk("pause_ready", 64'(ir_b), 64'd0);
        end
        @(posedge clk); #1 rdy = 1'b1;
        drain(1);
        chk("pause_end_occ", 64'(occ_b), 64'd0);
        ack_b = 1'b0;

        // Reset mid-operation discards in-flight and stored results.
        issue(1, 5'b00000, 32'd1, 32'd2, 4'd1, 32'd3);
        issue(1, 5'b00000, 32'd3, 32'd4, 4'd2, 32'd7);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ov", 64'(ov_b), 64'd0);
        chk("mid_rst_occ", 64'(occ_b), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_ov", 64'(ov_b), 64'd0);

        chk("qa_empty", 64'(qa.size()), 64'd0);
        chk("qb_empty", 64'(qb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
